// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and the bus command codes
// that the master and target controllers both understand.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } slave_state_t;

    typedef enum logic [2:0] {
        CMD_START,
        CMD_WR,
        CMD_RD,
        CMD_STOP,
        CMD_RESTART
    } bus_cmd_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an open-drain bus line with registered rise/fall
// strobes; idles high so reset looks like a released bus.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // level and strobes update together, three clocks after the pin edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            prev <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
            rise <= sync[1] & ~prev;
            fall <= ~sync[1] & prev;
        end
    end

    assign level = prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with one fixed 7-bit address: write bytes stream out on rx_data,
// read bytes are requested from the host one at a time via rd_req.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  tri         sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    output logic       start_tick,
    output logic       stop_tick,
    output logic       busy
);

    logic scl_in, scl_rise, scl_fall;
    logic sda_in, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (scl),
        .level (scl_in),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sda),
        .level (sda_in),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_in;
    assign stop_det  = sda_rise & scl_in;

    slave_state_t state, state_n;
    logic [2:0]   bit_cnt, bit_cnt_n;
    logic         last_bit, last_bit_n;
    logic [7:0]   shift, shift_n;
    logic [7:0]   tx_shift, tx_shift_n;
    logic         sda_oe, sda_oe_n;
    logic         busy_n, rw, rw_n;
    logic [7:0]   rx_data_n;
    logic         rx_valid_n, rd_req_n, start_tick_n, stop_tick_n;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            last_bit   <= 1'b0;
            shift      <= 8'h00;
            tx_shift   <= 8'h00;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            rw         <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rd_req     <= 1'b0;
            start_tick <= 1'b0;
            stop_tick  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            last_bit   <= last_bit_n;
            shift      <= shift_n;
            tx_shift   <= tx_shift_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            rw         <= rw_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            rd_req     <= rd_req_n;
            start_tick <= start_tick_n;
            stop_tick  <= stop_tick_n;
        end
    end

    // last_bit marks that the 8th rise has been sampled, so the SCL fall that
    // follows a START is not mistaken for the end of a bit
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        last_bit_n   = last_bit;
        shift_n      = shift;
        tx_shift_n   = tx_shift;
        sda_oe_n     = sda_oe;
        busy_n       = busy;
        rw_n         = rw;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        rd_req_n     = 1'b0;
        start_tick_n = 1'b0;
        stop_tick_n  = 1'b0;

        if (start_det) begin
            state_n      = ST_ADDR;
            bit_cnt_n    = 3'd0;
            last_bit_n   = 1'b0;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b0;
            start_tick_n = 1'b1;
        end else if (stop_det) begin
            state_n     = ST_IDLE;
            bit_cnt_n   = 3'd0;
            last_bit_n  = 1'b0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            stop_tick_n = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_n    = {shift[6:0], sda_in};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        last_bit_n = (bit_cnt == 3'd7);
                    end else if (scl_fall && last_bit) begin
                        last_bit_n = 1'b0;
                        if (state == ST_ADDR) begin
                            if (shift[7:1] == ADDR) begin
                                state_n  = ST_ADDR_ACK;
                                sda_oe_n = 1'b1;
                                busy_n   = 1'b1;
                                rw_n     = shift[0];
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                            sda_oe_n   = 1'b1;
                            state_n    = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw) begin
                        rd_req_n = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_n = 3'd0;
                        if (rw) begin
                            tx_shift_n = tx_data;
                            sda_oe_n   = ~tx_data[7];
                            state_n    = ST_RD_DATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                            sda_oe_n   = ~tx_shift[6];
                            bit_cnt_n  = bit_cnt + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_in) begin
                            rd_req_n = 1'b1;
                        end else begin
                            state_n = ST_IGNORE;
                            busy_n  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        tx_shift_n = tx_data;
                        sda_oe_n   = ~tx_data[7];
                        bit_cnt_n  = 3'd0;
                        state_n    = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master, host read-data model and
// scoreboard queues for written and read bytes.
module tb_i2c_slave;

    localparam int QTR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, rd_req, start_tick, stop_tick, busy;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.ADDR(7'h42)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rd_req     (rd_req),
        .start_tick (start_tick),
        .stop_tick  (stop_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // host side: presents the next queued read byte whenever rd_req pulses
    logic [7:0] tx_bytes [0:3];
    int         tx_idx = 0;
    always @(posedge clk) begin
        if (rd_req && tx_idx < 4) begin
            tx_data <= tx_bytes[tx_idx];
            tx_idx  <= tx_idx + 1;
        end
    end

    int rxv_cnt = 0, rdreq_cnt = 0, start_cnt = 0, stop_cnt = 0;
    int busy_cyc = 0, slave_low_cyc = 0;
    logic [7:0] obs_rx [$];
    logic [7:0] exp_rx [$];
    logic [7:0] exp_rd [$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            obs_rx.push_back(rx_data);
        end
        if (rd_req)     rdreq_cnt++;
        if (start_tick) start_cnt++;
        if (stop_tick)  stop_cnt++;
        if (busy)       busy_cyc++;
        if (sda === 1'b0 && !m_sda_low) slave_low_cyc++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        e = exp_rx.pop_front();
        check_output({tag, "_present"}, 32'(obs_rx.size()), 32'd1);
        if (obs_rx.size() > 0) check_output(tag, 32'(obs_rx.pop_front()), 32'(e));
    endtask

    task automatic wait_q();
        repeat (QTR) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; scl = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic bus_restart();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        b = sda; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(~master_ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int b_rx, b_rd, b_start, b_stop, b_busy, b_low;

        tx_bytes[0] = 8'h3C;
        tx_bytes[1] = 8'hC3;
        tx_bytes[2] = 8'h96;
        tx_bytes[3] = 8'hFF;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_sda",        32'(sda),        32'd1);
        check_output("rst_rx_data",    32'(rx_data),    32'h00);
        check_output("rst_rx_valid",   32'(rx_valid),   32'd0);
        check_output("rst_rd_req",     32'(rd_req),     32'd0);
        check_output("rst_start_tick", 32'(start_tick), 32'd0);
        check_output("rst_stop_tick",  32'(stop_tick),  32'd0);
        check_output("rst_busy",       32'(busy),       32'd0);
        rst = 1'b0;
        wait_q();

        // address match, write one byte
        b_rx = rxv_cnt; b_start = start_cnt; b_stop = stop_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check_output("t1_addr_ack", 32'(ack), 32'd0);
        check_output("t1_busy_on", 32'(busy), 32'd1);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check_output("t1_data_ack", 32'(ack), 32'd0);
        check_rx("t1_rx");
        bus_stop();
        wait_q();
        check_output("t1_busy_off", 32'(busy), 32'd0);
        check_output("t1_rx_pulses", 32'(rxv_cnt - b_rx), 32'd1);
        check_output("t1_starts", 32'(start_cnt - b_start), 32'd1);
        check_output("t1_stops", 32'(stop_cnt - b_stop), 32'd1);

        // address mismatch
        b_rx = rxv_cnt; b_rd = rdreq_cnt; b_busy = busy_cyc; b_low = slave_low_cyc;
        bus_start();
        write_byte(8'h86, ack);
        check_output("t2_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h11, ack);
        check_output("t2_data_nack", 32'(ack), 32'd1);
        bus_stop();
        wait_q();
        check_output("t2_no_drive", 32'(slave_low_cyc - b_low), 32'd0);
        check_output("t2_no_rx", 32'(rxv_cnt - b_rx), 32'd0);
        check_output("t2_no_rd_req", 32'(rdreq_cnt - b_rd), 32'd0);
        check_output("t2_no_busy", 32'(busy_cyc - b_busy), 32'd0);

        // read two bytes, ACK then NACK
        b_rd = rdreq_cnt;
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        bus_start();
        write_byte(8'h85, ack);
        check_output("t3_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd);
        check_output("t3_rd0", 32'(rd), 32'(exp_rd.pop_front()));
        read_byte(1'b0, rd);
        check_output("t3_rd1", 32'(rd), 32'(exp_rd.pop_front()));
        check_output("t3_released", 32'(sda), 32'd1);
        check_output("t3_busy_off", 32'(busy), 32'd0);
        check_output("t3_rd_reqs", 32'(rdreq_cnt - b_rd), 32'd2);
        bus_stop();

        // write, repeated START, read
        b_start = start_cnt;
        exp_rd.push_back(8'h96);
        bus_start();
        write_byte(8'h84, ack);
        check_output("t4_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check_rx("t4_rx");
        bus_restart();
        write_byte(8'h85, ack);
        check_output("t4_raddr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, rd);
        check_output("t4_rd", 32'(rd), 32'(exp_rd.pop_front()));
        bus_stop();
        wait_q();
        check_output("t4_rx_data", 32'(rx_data), 32'h5A);
        check_output("t4_starts", 32'(start_cnt - b_start), 32'd2);

        // STOP after half a data byte, then bits without a START
        b_rx = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check_output("t5_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        wait_q();
        check_output("t5_no_rx", 32'(rxv_cnt - b_rx), 32'd0);
        check_output("t5_rx_hold", 32'(rx_data), 32'h5A);
        check_output("t5_busy_off", 32'(busy), 32'd0);
        b_low = slave_low_cyc;
        scl = 1'b0; wait_q();
        write_byte(8'h84, ack);
        check_output("t5_idle_nack", 32'(ack), 32'd1);
        check_output("t5_idle_no_drive", 32'(slave_low_cyc - b_low), 32'd0);
        bus_stop();

        // reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i));
        m_sda_low = 1'b0;
        @(posedge clk); #1;
        check_output("t6_ack_drive", 32'(sda), 32'd0);
        rst = 1'b1;
        #1;
        check_output("t6_rst_release", 32'(sda), 32'd1);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        check_output("t6_rst_rx_data", 32'(rx_data), 32'h00);
        check_output("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_q();
        bus_stop();
        bus_start();
        write_byte(8'h84, ack);
        check_output("t6_post_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack);
        check_output("t6_post_data_ack", 32'(ack), 32'd0);
        check_rx("t6_rx");
        bus_stop();
        wait_q();
        check_output("t6_rx_data", 32'(rx_data), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) controller that responds to one fixed 7-bit address. It sits on the same open-drain SCL/SDA pair that `i2c_master` drives. Master writes are delivered to the host as a byte stream, and master reads are served from bytes the host supplies on request. SCL is only observed, never driven: the block does no clock stretching, supports standard/fast mode, and does not recognise general-call or 10-bit addressing.

## Interface
Parameters:
- `ADDR`, 7'h42, own 7-bit target address.

Ports:
- `clk`  input  1  system clock; must run at ≥16× the SCL frequency.
- `rst`  input  1  asynchronous, active-high reset.
- `scl`  input  1  bus clock, sampled only.
- `sda`  inout tri  1  bus data; driven `1'b0` or `1'bz`, never `1'b1`.
- `tx_data`  input  8  byte returned to the master on reads; latched as described under Operation.
- `rx_data`  output  8  last byte written by the master.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` is new.
- `rd_req`  output  1  one-cycle pulse; host must present the next `tx_data`.
- `start_tick`  output  1  one-cycle pulse on START or repeated START.
- `stop_tick`  output  1  one-cycle pulse on STOP.
- `busy`  output  1  high from an address match until STOP, START, or master NACK.

## Operation
- **Input conditioning.** `scl` and `sda` each pass through a 2-FF synchronizer (reset value 1) plus a previous-value flop. This yields `scl_rise`, `scl_fall` and `sda_rise`, `sda_fall` strobes.
- **START.** `sda_fall` while synced SCL is high. From any state: go to ADDR, clear the bit counter, release SDA, pulse `start_tick`.
- **STOP.** `sda_rise` while synced SCL is high. From any state: go to IDLE, release SDA, pulse `stop_tick`, deassert `busy`.
- START and STOP take priority over every bit-level transition in the same cycle.
- **Bit timing.** Data bits are sampled on `scl_rise`. The SDA drive register `sda_oe` changes only on `scl_fall`. `sda = sda_oe ? 1'b0 : 1'bz`.
- **States.** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- **Bit counter.** 3 bits, counts 0..7. Shift registers are 8 bits, MSB first.
- **IDLE.** SDA released. Only START leaves this state.
- **ADDR.** Shift in 8 bits. On the 8th `scl_fall`:
  - if `shift[7:1] == ADDR`: go to ADDR_ACK, set `sda_oe=1`, set `busy=1`, latch R/W = `shift[0]`;
  - otherwise: go to IGNORE.
- **ADDR_ACK.** On the next `scl_fall`:
  - write (R/W=0): release SDA, go to WR_DATA;
  - read (R/W=1): load the tx shift register from `tx_data`, drive its bit 7, go to RD_DATA.
  - `rd_req` pulses on the `scl_rise` of the ACK slot.
- **WR_DATA.** Shift in 8 bits. On the 8th `scl_fall`: `rx_data` ← shift, pulse `rx_valid`, set `sda_oe=1`, go to WR_ACK. The block always ACKs data bytes.
- **WR_ACK.** On `scl_fall`: release SDA, go to WR_DATA.
- **RD_DATA.** On each `scl_fall`, shift and drive the next bit (`sda_oe = ~bit`). After the 8th `scl_fall`, release SDA and go to RD_ACK.
- **RD_ACK.** Sample the master's bit on `scl_rise`:
  - 0 (ACK): pulse `rd_req` in that cycle. On the next `scl_fall`, load `tx_data` and go to RD_DATA.
  - 1 (NACK): go to IGNORE, `busy=0`.
- **IGNORE.** SDA released. Waits for START or STOP.

## Timing
- **Reset values.** `sda` released (`sda_oe=0`), `rx_data=8'h00`, all pulses 0, `busy=0`, state IDLE, counters 0.
- **Edge latency.** Physical SCL/SDA edge to strobe: 3 clk (2 sync + 1 edge detect). Strobe to `sda_oe` change: 1 clk, for 4 clk total after the physical SCL fall.
- **Host `tx_data` window.** `tx_data` must be stable from the `rd_req` pulse until the following `scl_fall` strobe, i.e. about half an SCL period.
- **`rx_valid`.** Pulses in the cycle after the 8th data `scl_fall` strobe. `rx_data` holds until the next byte completes.
- **Reset mid-transfer.** Asserting reset mid-transfer releases SDA immediately (asynchronous). After reset, the block ignores the bus until the next START.
- **Aborted bytes.** START or STOP mid-byte discards the partial byte: no `rx_valid`, no drive.

## Structure
- Package `i2c_pkg`:
  - the `i2c_slave` state enum;
  - shared bus constants (command codes START/WR/RD/STOP/RESTART, also used by `i2c_master`).
- Sub-module `i2c_sync_edge`: 2-FF synchronizer with rise/fall strobes, reset value 1. It is instantiated twice, once for `scl` and once for `sda`.

## Test plan
1. **Address match, write.** ADDR=7'h42; master sends START, 0x84, 0xA5, STOP. Required: SDA pulled low in both ACK slots, `rx_valid` pulses once with `rx_data=8'hA5`, `busy` 1→0 at STOP, one `start_tick` and one `stop_tick`.
2. **Address mismatch.** START, 0x86, 0x11, STOP. Required: SDA never driven low, no `rx_valid`, no `rd_req`, `busy` stays 0.
3. **Read with NACK.** START, 0x85; host supplies `tx_data=8'h3C` then `8'hC3`; master ACKs byte 1, NACKs byte 2. Required: SDA carries 0011_1100 then 1100_0011, `rd_req` pulses twice, SDA released after the NACK, `busy=0`.
4. **Repeated START.** Write 0x84 then 0x5A, repeated START, 0x85, read one byte. Required: `rx_data=8'h5A`, two `start_tick` pulses, correct read data.
5. **STOP mid-byte.** STOP after 4 bits of a write data byte. Required: no `rx_valid`, `rx_data` unchanged, state IDLE.
6. **Reset mid-drive.** Reset asserted while the block drives the ACK or a 0 read bit. Required: SDA released within the same cycle, all outputs at reset values, the next transaction after START works normally.
